// File: rtl/pwm_bank_ctrl.sv
// pwm_bank_ctrl: register bank and PWM generator for the 8-pin pad buffer.
// Duty/period are shadowed and applied at period wrap.
module pwm_bank_ctrl #(
    parameter int CHANNELS  = 8,
    parameter int CNT_WIDTH = 8,
    parameter int PRE_WIDTH = 8
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic                  WrEn,
    input  logic [3:0]            WrAddr,
    input  logic [15:0]           WrData,
    input  logic [3:0]            RdAddr,
    output logic [15:0]           RdData,
    output logic [2*CHANNELS-1:0] Mode,
    output logic [CHANNELS-1:0]   Output,
    output logic [CHANNELS-1:0]   PWM,
    output logic                  PeriodTick
);

    typedef logic [CHANNELS-1:0][CNT_WIDTH-1:0] duty_arr_t;

    logic [2*CHANNELS-1:0] mode_q, mode_d;
    logic [CHANNELS-1:0]   out_q, out_d;
    logic [CNT_WIDTH-1:0]  period_sh_q, period_sh_d;
    logic [CNT_WIDTH-1:0]  period_act_q, period_act_d;
    logic [PRE_WIDTH-1:0]  pre_q, pre_d;
    logic                  en_q, en_d;
    duty_arr_t             duty_sh_q, duty_sh_d;
    duty_arr_t             duty_act_q, duty_act_d;
    logic [PRE_WIDTH-1:0]  pre_cnt_q, pre_cnt_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CHANNELS-1:0]   pwm_q, pwm_d;
    logic                  ptick_q, ptick_d;
    logic [15:0]           rd_q, rd_d;

    // Counting only while enabled now and not being disabled this cycle,
    // so a Ctrl clear drops PWM and the counters on the very next edge.
    logic run;
    logic tick;
    logic wrap;

    assign run  = en_q & en_d;
    assign tick = run && (pre_cnt_q == pre_q);
    assign wrap = tick && (cnt_q == period_act_q);

    assign Mode       = mode_q;
    assign Output     = out_q;
    assign PWM        = pwm_q;
    assign PeriodTick = ptick_q;
    assign RdData     = rd_q;

    // Register-bus write decode into the configuration and shadow registers.
    always_comb begin
        mode_d      = mode_q;
        out_d       = out_q;
        period_sh_d = period_sh_q;
        pre_d       = pre_q;
        en_d        = en_q;
        duty_sh_d   = duty_sh_q;
        if (WrEn) begin
            case (WrAddr)
                4'd0:    mode_d      = WrData[2*CHANNELS-1:0];
                4'd1:    out_d       = WrData[CHANNELS-1:0];
                4'd2:    period_sh_d = WrData[CNT_WIDTH-1:0];
                4'd3:    pre_d       = WrData[PRE_WIDTH-1:0];
                4'd4:    en_d        = WrData[0];
                default: ;
            endcase
            for (int i = 0; i < CHANNELS; i++) begin
                if (WrAddr == 4'(8 + i)) begin
                    duty_sh_d[i] = WrData[CNT_WIDTH-1:0];
                end
            end
        end
    end

    // Prescaler, period counter, wrap-time shadow transfer and PWM compare.
    always_comb begin
        pre_cnt_d    = '0;
        cnt_d        = '0;
        period_act_d = period_act_q;
        duty_act_d   = duty_act_q;
        pwm_d        = '0;
        ptick_d      = 1'b0;
        if (run) begin
            // A prescaler above a freshly lowered Prescale falls to 0 silently.
            if (pre_cnt_q < pre_q) begin
                pre_cnt_d = pre_cnt_q + 1'b1;
            end
            if (wrap) begin
                cnt_d        = '0;
                period_act_d = period_sh_q;
                duty_act_d   = duty_sh_q;
                ptick_d      = 1'b1;
            end else if (tick) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d = cnt_q;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                pwm_d[i] = (cnt_q < duty_act_q[i]);
            end
        end else begin
            period_act_d = period_sh_q;
            duty_act_d   = duty_sh_q;
        end
    end

    // Registered read mux; unmapped addresses return zero.
    always_comb begin
        rd_d = '0;
        case (RdAddr)
            4'd0:    rd_d = 16'(mode_q);
            4'd1:    rd_d = 16'(out_q);
            4'd2:    rd_d = 16'(period_sh_q);
            4'd3:    rd_d = 16'(pre_q);
            4'd4:    rd_d = {15'd0, en_q};
            default: ;
        endcase
        for (int i = 0; i < CHANNELS; i++) begin
            if (RdAddr == 4'(8 + i)) begin
                rd_d = 16'(duty_sh_q[i]);
            end
        end
    end

    // State register with asynchronous clear to the idle/hi-Z state.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            mode_q       <= '0;
            out_q        <= '0;
            period_sh_q  <= '1;
            period_act_q <= '1;
            pre_q        <= '0;
            en_q         <= 1'b0;
            duty_sh_q    <= '0;
            duty_act_q   <= '0;
            pre_cnt_q    <= '0;
            cnt_q        <= '0;
            pwm_q        <= '0;
            ptick_q      <= 1'b0;
            rd_q         <= '0;
        end else begin
            mode_q       <= mode_d;
            out_q        <= out_d;
            period_sh_q  <= period_sh_d;
            period_act_q <= period_act_d;
            pre_q        <= pre_d;
            en_q         <= en_d;
            duty_sh_q    <= duty_sh_d;
            duty_act_q   <= duty_act_d;
            pre_cnt_q    <= pre_cnt_d;
            cnt_q        <= cnt_d;
            pwm_q        <= pwm_d;
            ptick_q      <= ptick_d;
            rd_q         <= rd_d;
        end
    end

endmodule

// File: tb/tb_pwm_bank_ctrl.sv
// tb_pwm_bank_ctrl: directed vectors for pwm_bank_ctrl.
// Expected waveforms are hand-derived per cycle after enable.
module tb_pwm_bank_ctrl;

    logic        Clock   = 1'b0;
    logic        Reset_n = 1'b1;
    logic        WrEn    = 1'b0;
    logic [3:0]  WrAddr  = '0;
    logic [15:0] WrData  = '0;
    logic [3:0]  RdAddr  = '0;
    logic [15:0] RdData;
    logic [15:0] Mode;
    logic [7:0]  Output;
    logic [7:0]  PWM;
    logic        PeriodTick;

    int nvec = 0;
    int nerr = 0;

    always #5 Clock = ~Clock;

    pwm_bank_ctrl dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .WrEn       (WrEn),
        .WrAddr     (WrAddr),
        .WrData     (WrData),
        .RdAddr     (RdAddr),
        .RdData     (RdData),
        .Mode       (Mode),
        .Output     (Output),
        .PWM        (PWM),
        .PeriodTick (PeriodTick)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        WrEn   = 1'b1;
        WrAddr = a;
        WrData = d;
        step();
        WrEn   = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [15:0] d);
        RdAddr = a;
        step();
        d = RdData;
    endtask

    initial begin
        logic [15:0] r;
        logic [2:0]  e3;
        logic        e;
        int          dt [4];

        // Reset state
        #3 Reset_n = 1'b0;
        #1;
        chk("rst_mode", 32'(Mode), 32'h0);
        chk("rst_out", 32'(Output), 32'h0);
        chk("rst_pwm", 32'(PWM), 32'h0);
        chk("rst_ptick", 32'(PeriodTick), 32'h0);
        step();
        step();
        #2 Reset_n = 1'b1;
        rd(4'd2, r);
        chk("rst_period", 32'(r), 32'h00FF);
        rd(4'd3, r);
        chk("rst_prescale", 32'(r), 32'h0);

        // Config passthrough
        wr(4'd0, 16'hA5C3);
        chk("mode", 32'(Mode), 32'hA5C3);
        wr(4'd1, 16'h005A);
        chk("output", 32'(Output), 32'h5A);
        rd(4'd0, r);
        chk("rd_mode", 32'(r), 32'hA5C3);
        rd(4'd1, r);
        chk("rd_output", 32'(r), 32'h005A);
        wr(4'd6, 16'hFFFF);
        chk("unmapped_mode", 32'(Mode), 32'hA5C3);
        chk("unmapped_out", 32'(Output), 32'h5A);
        rd(4'd6, r);
        chk("rd_unmapped", 32'(r), 32'h0);
        rd(4'd4, r);
        chk("rd_ctrl_off", 32'(r), 32'h0);

        // Basic PWM: period 4, no prescale, duties 2/0/7
        wr(4'd2, 16'd4);
        wr(4'd3, 16'd0);
        wr(4'd8, 16'd2);
        wr(4'd9, 16'd0);
        wr(4'd10, 16'd7);
        wr(4'd4, 16'd1);
        chk("basic_c0", 32'(PWM[2:0]), 32'h0);
        for (int k = 1; k <= 15; k++) begin
            step();
            e3 = {1'b1, 1'b0, (((k - 1) % 5) < 2)};
            chk("basic_pwm", 32'(PWM[2:0]), 32'(e3));
            chk("basic_ptick", 32'(PeriodTick), 32'((k % 5) == 0));
        end
        wr(4'd4, 16'd0);
        chk("dis_pwm", 32'(PWM), 32'h0);

        // Prescaler: period 3, prescale 2, duty 1
        wr(4'd2, 16'd3);
        wr(4'd3, 16'd2);
        wr(4'd8, 16'd1);
        wr(4'd4, 16'd1);
        for (int k = 1; k <= 24; k++) begin
            step();
            e = (((k - 1) / 3) % 4) == 0;
            chk("pre_pwm", 32'(PWM[0]), 32'(e));
            chk("pre_ptick", 32'(PeriodTick), 32'((k % 12) == 0));
        end
        wr(4'd4, 16'd0);

        // Double buffering: period 9, duty 5 -> 8 mid-period, 2 at wrap
        wr(4'd2, 16'd9);
        wr(4'd3, 16'd0);
        wr(4'd8, 16'd5);
        wr(4'd4, 16'd1);
        dt = '{5, 8, 8, 2};
        for (int k = 1; k <= 40; k++) begin
            if (k == 4) begin
                WrEn = 1'b1; WrAddr = 4'd8; WrData = 16'd8;
            end else if (k == 20) begin
                WrEn = 1'b1; WrAddr = 4'd8; WrData = 16'd2;
            end else begin
                WrEn = 1'b0;
            end
            step();
            e = ((k - 1) % 10) < dt[(k - 1) / 10];
            chk("dbuf_pwm", 32'(PWM[0]), 32'(e));
            chk("dbuf_ptick", 32'(PeriodTick), 32'((k % 10) == 0));
        end
        WrEn = 1'b0;
        rd(4'd8, r);
        chk("rd_duty0", 32'(r), 32'd2);
        rd(4'd2, r);
        chk("rd_period", 32'(r), 32'd9);

        // Enable toggle: clear at Cnt=2, reprogram duty, restart
        wr(4'd4, 16'd0);
        wr(4'd4, 16'd1);
        step();
        step();
        chk("tog_pre", 32'(PWM[0]), 32'h1);
        wr(4'd4, 16'd0);
        chk("tog_off_pwm", 32'(PWM), 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("tog_idle_pwm", 32'(PWM), 32'h0);
            chk("tog_idle_ptick", 32'(PeriodTick), 32'h0);
        end
        wr(4'd8, 16'd3);
        wr(4'd4, 16'd1);
        for (int k = 1; k <= 12; k++) begin
            step();
            e = ((k - 1) % 10) < 3;
            chk("tog_pwm", 32'(PWM[0]), 32'(e));
            chk("tog_ptick", 32'(PeriodTick), 32'((k % 10) == 0));
        end

        // Asynchronous reset mid-waveform
        chk("pre_rst_pwm", 32'(PWM[0]), 32'h1);
        chk("pre_rst_mode", 32'(Mode), 32'hA5C3);
        #2 Reset_n = 1'b0;
        #1;
        chk("arst_mode", 32'(Mode), 32'h0);
        chk("arst_out", 32'(Output), 32'h0);
        chk("arst_pwm", 32'(PWM), 32'h0);
        chk("arst_ptick", 32'(PeriodTick), 32'h0);
        step();
        step();
        #2 Reset_n = 1'b1;
        rd(4'd2, r);
        chk("arst_rd_period", 32'(r), 32'h00FF);
        rd(4'd8, r);
        chk("arst_rd_duty0", 32'(r), 32'h0);
        rd(4'd4, r);
        chk("arst_rd_ctrl", 32'(r), 32'h0);
        step();
        chk("arst_idle_pwm", 32'(PWM), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
